// File: rtl/fix_pkg.sv
// Shared constants, state encoding and ROM address packing for the fix-layer
// tile row fetcher.
package fix_pkg;

   localparam int TILE_W      = 12;
   localparam int X_W         = 9;
   localparam int MA_W        = 17;
   localparam int MA_TILE_LSB = 5;
   localparam int MA_HALF_BIT = 4;
   localparam int MA_ROW_LSB  = 0;

   localparam logic [3:0] COLOUR_CLEAR = 4'h0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_EMIT
   } fix_state_e;

   // Bit 3 of the address is always zero; half = 1 selects the left pixels.
   function automatic logic [MA_W-1:0] fix_addr(input logic [TILE_W-1:0] code,
                                                input logic              half,
                                                input logic [2:0]        row);
      logic [MA_W-1:0] a;
      a                         = '0;
      a[MA_W-1:MA_TILE_LSB]     = code;
      a[MA_HALF_BIT]            = half;
      a[MA_ROW_LSB +: 3]        = row;
      return a;
   endfunction

endpackage

// File: rtl/fix_fetch_if.sv
// Fix ROM read port: one-cycle request pulse, acknowledge carries the data.
interface fix_fetch_if;
   import fix_pkg::*;

   logic            msreq;
   logic [MA_W-1:0] msaddr;
   logic            msack;
   logic [15:0]     msdata;

   modport master (output msreq, output msaddr, input msack, input msdata);
   modport slave  (input msreq, input msaddr, output msack, output msdata);

endinterface

// File: rtl/fix_pix_shift.sv
// Four-pixel unpacker: holds one ROM half-row and offers the next nibble to
// emit together with its index within the half (0 = leftmost).
module fix_pix_shift (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        shift,
   input  logic [15:0] din,
   output logic [3:0]  nxt_nib,
   output logic [1:0]  nxt_idx,
   output logic        last
);

   logic [11:0] sr_q, sr_d;
   logic [1:0]  idx_q, idx_d;

   // Pixel 0 goes straight from din to the output registers, so only the
   // remaining three pixels are kept here.
   always_comb begin
      sr_d  = sr_q;
      idx_d = idx_q;
      if (load) begin
         sr_d  = din[15:4];
         idx_d = 2'd0;
      end else if (shift) begin
         sr_d  = {4'h0, sr_q[11:4]};
         idx_d = idx_q + 2'd1;
      end
   end

   assign nxt_nib = load ? din[3:0] : sr_q[3:0];
   assign nxt_idx = load ? 2'd0 : idx_q + 2'd1;
   assign last    = (idx_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         idx_q <= 2'd0;
      end else begin
         sr_q  <= sr_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/fix_fetch.sv
// Fix tile row fetcher: takes one tile-row job, reads the left and right
// halves from the fix ROM and writes 8 palette-tagged pixels to the line buffer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | tile_ready high, waiting for a job
// ST_REQ  | msreq pulse on the bus for the current half
// ST_WAIT | read outstanding, waiting for msack
// ST_EMIT | one pixel per cycle on pix_*; pixel index tracked by fix_pix_shift
module fix_fetch
   import fix_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tile_valid,
   output logic              tile_ready,
   input  logic [TILE_W-1:0] tile_code,
   input  logic [2:0]        tile_row,
   input  logic [3:0]        tile_pal,
   input  logic [X_W-1:0]    tile_x,
   fix_fetch_if.master       rom,
   output logic              pix_we,
   output logic [X_W-1:0]    pix_x,
   output logic [7:0]        pix_data
);

   fix_state_e        state_q, state_d;
   logic              half_q, half_d;
   logic [TILE_W-1:0] code_q, code_d;
   logic [2:0]        row_q, row_d;
   logic [3:0]        pal_q, pal_d;
   logic [X_W-1:0]    x_q, x_d;
   logic              msreq_q, msreq_d;
   logic [MA_W-1:0]   msaddr_q, msaddr_d;
   logic              tile_ready_q, tile_ready_d;
   logic              pix_we_q, pix_we_d;
   logic [X_W-1:0]    pix_x_q, pix_x_d;
   logic [7:0]        pix_data_q, pix_data_d;

   logic       sh_load, sh_shift, sh_last, emit;
   logic [3:0] sh_nib;
   logic [1:0] sh_idx;

   fix_pix_shift u_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (sh_load),
      .shift   (sh_shift),
      .din     (rom.msdata),
      .nxt_nib (sh_nib),
      .nxt_idx (sh_idx),
      .last    (sh_last)
   );

   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      code_d     = code_q;
      row_d      = row_q;
      pal_d      = pal_q;
      x_d        = x_q;
      msreq_d    = 1'b0;
      msaddr_d   = msaddr_q;
      pix_we_d   = 1'b0;
      pix_x_d    = pix_x_q;
      pix_data_d = pix_data_q;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      emit       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tile_valid && tile_ready_q) begin
               code_d   = tile_code;
               row_d    = tile_row;
               pal_d    = tile_pal;
               x_d      = tile_x;
               half_d   = 1'b1;
               msreq_d  = 1'b1;
               msaddr_d = fix_addr(tile_code, 1'b1, tile_row);
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (rom.msack) begin
               sh_load = 1'b1;
               emit    = 1'b1;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (sh_last) begin
               if (half_q) begin
                  half_d   = 1'b0;
                  msreq_d  = 1'b1;
                  msaddr_d = fix_addr(code_q, 1'b0, row_q);
                  state_d  = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               sh_shift = 1'b1;
               emit     = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Right half lands 4 pixels to the right; x wraps at the line end.
      if (emit) begin
         pix_we_d   = (sh_nib != COLOUR_CLEAR);
         pix_x_d    = x_q + {{(X_W-3){1'b0}}, ~half_q, sh_idx};
         pix_data_d = {pal_q, sh_nib};
      end

      tile_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         half_q       <= 1'b0;
         code_q       <= '0;
         row_q        <= '0;
         pal_q        <= '0;
         x_q          <= '0;
         msreq_q      <= 1'b0;
         msaddr_q     <= '0;
         tile_ready_q <= 1'b0;
         pix_we_q     <= 1'b0;
         pix_x_q      <= '0;
         pix_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         half_q       <= half_d;
         code_q       <= code_d;
         row_q        <= row_d;
         pal_q        <= pal_d;
         x_q          <= x_d;
         msreq_q      <= msreq_d;
         msaddr_q     <= msaddr_d;
         tile_ready_q <= tile_ready_d;
         pix_we_q     <= pix_we_d;
         pix_x_q      <= pix_x_d;
         pix_data_q   <= pix_data_d;
      end
   end

   assign tile_ready = tile_ready_q;
   assign rom.msreq  = msreq_q;
   assign rom.msaddr = msaddr_q;
   assign pix_we     = pix_we_q;
   assign pix_x      = pix_x_q;
   assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_fix_fetch.sv
// Directed bench for fix_fetch: drives tile jobs, plays the ROM responder and
// checks bus timing and pixel writes against a queue of expected writes.
module tb_fix_fetch;
   import fix_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tile_valid;
   logic        tile_ready;
   logic [11:0] tile_code;
   logic [2:0]  tile_row;
   logic [3:0]  tile_pal;
   logic [8:0]  tile_x;
   logic        pix_we;
   logic [8:0]  pix_x;
   logic [7:0]  pix_data;

   fix_fetch_if rom_if ();

   logic [16:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int n_writes = 0;
   int n0;

   always #5 clk = ~clk;

   fix_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .tile_code  (tile_code),
      .tile_row   (tile_row),
      .tile_pal   (tile_pal),
      .tile_x     (tile_x),
      .rom        (rom_if),
      .pix_we     (pix_we),
      .pix_x      (pix_x),
      .pix_data   (pix_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every line-buffer write must match the oldest expected write.
   always @(negedge clk) begin
      if (pix_we === 1'b1) begin
         n_writes++;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_write observed=%0h expected=none", {pix_x, pix_data});
         end
         if (exp_q.size() != 0)
            chk("pix_write", 32'({pix_x, pix_data}), 32'(exp_q.pop_front()));
      end
   end

   // Called at a negedge with the block idle; returns at the negedge of the
   // cycle in which tile_ready is high again.
   task automatic run_job(input logic [11:0] code, input logic [2:0] row,
                          input logic [3:0] pal, input logic [8:0] x,
                          input logic [15:0] dl, input logic [15:0] dr,
                          input int stall, input bit hold_valid, input bit spur);
      logic [16:0] al, ar;
      logic [31:0] dd;
      logic [3:0]  nib;
      logic [8:0]  px;
      al = {code, 1'b1, 1'b0, row};
      ar = {code, 1'b0, 1'b0, row};
      dd = {dr, dl};
      for (int i = 0; i < 8; i++) begin
         nib = dd[4*i +: 4];
         px  = x + 9'(i);
         if (nib != 4'h0) exp_q.push_back({px, pal, nib});
      end
      chk("ready_idle", 32'(tile_ready), 32'd1);
      tile_valid = 1'b1;
      tile_code  = code;
      tile_row   = row;
      tile_pal   = pal;
      tile_x     = x;
      for (int h = 0; h < 2; h++) begin
         @(negedge clk);
         if (!hold_valid) tile_valid = 1'b0;
         tile_code = ~code;
         tile_row  = ~row;
         tile_pal  = ~pal;
         tile_x    = x + 9'd50;
         chk("msreq_pulse", 32'(rom_if.msreq), 32'd1);
         chk("msaddr", 32'(rom_if.msaddr), 32'(h == 0 ? al : ar));
         chk("ready_busy", 32'(tile_ready), 32'd0);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("msreq_single", 32'(rom_if.msreq), 32'd0);
            chk("msaddr_hold", 32'(rom_if.msaddr), 32'(h == 0 ? al : ar));
         end
         @(negedge clk);
         chk("msreq_wait", 32'(rom_if.msreq), 32'd0);
         chk("msaddr_ack", 32'(rom_if.msaddr), 32'(h == 0 ? al : ar));
         rom_if.msack  = 1'b1;
         rom_if.msdata = (h == 0) ? dl : dr;
         @(negedge clk);
         rom_if.msack  = 1'b0;
         rom_if.msdata = 16'hDEAD;
         for (int p = 0; p < 4; p++) begin
            nib = dd[16*h + 4*p +: 4];
            chk("pix_we_timing", 32'(pix_we), 32'(nib != 4'h0));
            chk("msreq_emit", 32'(rom_if.msreq), 32'd0);
            rom_if.msack = spur && (p == 1);
            if (spur && p == 1) rom_if.msdata = 16'hFFFF;
            if (p < 3) @(negedge clk);
         end
         rom_if.msack = 1'b0;
      end
      chk("ready_last_pixel", 32'(tile_ready), 32'd0);
      @(negedge clk);
      tile_valid = 1'b0;
      chk("ready_done", 32'(tile_ready), 32'd1);
      chk("msreq_done", 32'(rom_if.msreq), 32'd0);
      chk("writes_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      tile_valid    = 1'b0;
      tile_code     = '0;
      tile_row      = '0;
      tile_pal      = '0;
      tile_x        = '0;
      rom_if.msack  = 1'b0;
      rom_if.msdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(tile_ready), 32'd0);
      chk("rst_msreq", 32'(rom_if.msreq), 32'd0);
      chk("rst_msaddr", 32'(rom_if.msaddr), 32'd0);
      chk("rst_pix_we", 32'(pix_we), 32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_job(12'h123, 3'd5, 4'hA, 9'd100, 16'h4321, 16'h8765, 0, 1'b0, 1'b0);

      n0 = n_writes;
      run_job(12'h7FF, 3'd0, 4'h3, 9'd40, 16'h0F00, 16'h0000, 0, 1'b0, 1'b0);
      chk("transparent_count", 32'(n_writes - n0), 32'd1);

      run_job(12'h0F0, 3'd2, 4'h6, 9'd509, 16'h4321, 16'h8765, 0, 1'b0, 1'b0);
      run_job(12'hABC, 3'd7, 4'h1, 9'd300, 16'h1234, 16'h5678, 5, 1'b0, 1'b0);

      // Stray acknowledge while idle.
      rom_if.msack  = 1'b1;
      rom_if.msdata = 16'hFFFF;
      @(negedge clk);
      rom_if.msack = 1'b0;
      chk("idle_ack_ready", 32'(tile_ready), 32'd1);
      chk("idle_ack_msreq", 32'(rom_if.msreq), 32'd0);
      @(negedge clk);
      chk("idle_ack_pix_we", 32'(pix_we), 32'd0);

      n0 = n_writes;
      run_job(12'h001, 3'd1, 4'hF, 9'd0, 16'h9ABC, 16'hDEF1, 0, 1'b1, 1'b1);
      chk("hold_valid_count", 32'(n_writes - n0), 32'd8);

      // Reset while a read is outstanding; its ack arrives after release.
      tile_valid = 1'b1;
      tile_code  = 12'h055;
      tile_row   = 3'd2;
      tile_pal   = 4'h5;
      tile_x     = 9'd20;
      @(negedge clk);
      tile_valid = 1'b0;
      chk("abort_msreq", 32'(rom_if.msreq), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(tile_ready), 32'd0);
      chk("abort_msreq_rst", 32'(rom_if.msreq), 32'd0);
      chk("abort_msaddr", 32'(rom_if.msaddr), 32'd0);
      chk("abort_pix_we", 32'(pix_we), 32'd0);
      chk("abort_pix_x", 32'(pix_x), 32'd0);
      chk("abort_pix_data", 32'(pix_data), 32'd0);
      rst_n         = 1'b1;
      rom_if.msack  = 1'b1;
      rom_if.msdata = 16'h1111;
      @(negedge clk);
      rom_if.msack = 1'b0;
      chk("stale_ack_ready", 32'(tile_ready), 32'd1);
      chk("stale_ack_msreq", 32'(rom_if.msreq), 32'd0);
      chk("stale_ack_pix_we", 32'(pix_we), 32'd0);
      @(negedge clk);
      chk("stale_ack_pix_we2", 32'(pix_we), 32'd0);

      run_job(12'h3C5, 3'd3, 4'h2, 9'd200, 16'h2468, 16'h1357, 0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
